ternary_neuron_accum: RTL and testbench
=======================================

Name: ternary_neuron_accum

Overview:
- Sequential stage directly downstream of the approximate popcount24 circuits in the printed ternary-neuron datapath.
- Per beat, consumes two 5-bit popcounts for one 24-input chunk:
  - pos_cnt: matches against +1 weights.
  - neg_cnt: matches against -1 weights.
- Accumulates the signed difference over N_CHUNKS beats, thresholds the sum and emits a 2-bit ternary activation over a valid/ready handshake.
- Popcount inputs are approximate, so any 5-bit value 0..31 is legal; the block must not assume values ≤24.

Parameters:
N_CHUNKS  4  beats (24-input chunks) per neuron evaluation; legal range 1..16
ACC_W     8  signed accumulator and threshold width in bits; legal range 6..12

Ports:
clk        input   1       clock; all state updates on rising edge
rst        input   1       synchronous, active-high reset
in_valid   input   1       pos_cnt/neg_cnt/in_last valid this cycle
in_ready   output  1       block can accept a beat
pos_cnt    input   5       unsigned popcount of +1-weight matches
neg_cnt    input   5       unsigned popcount of -1-weight matches
in_last    input   1       producer marks final chunk of the neuron
thr_hi     input   ACC_W   signed upper threshold; sampled on chunk-0 beat
thr_lo     input   ACC_W   signed lower threshold; sampled on chunk-0 beat
out_valid  output  1       result valid
out_ready  input   1       consumer accepts result
out_act    output  2       ternary activation: 2'b01 = +1, 2'b00 = 0, 2'b11 = -1
out_sum    output  ACC_W   final signed accumulator value
out_err    output  1       in_last framing mismatch in this evaluation
out_sat    output  1       accumulator clamped in this evaluation (0 when feature disabled)

Behaviour:
- Reset (synchronous, active-high):
  - Sum, chunk counter, sampled thresholds, sticky err/sat flags and all outputs → 0.
  - in_ready = 1 the cycle after rst deasserts.
  - rst asserted mid-evaluation discards the partial sum and any pending result.
- States:
  - ACC: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, out_valid = 1.
- Beat accepted when in_valid & in_ready.
  - d = {0,pos_cnt} − {0,neg_cnt}: 6-bit signed, range −31..31, sign-extended to ACC_W.
  - Chunk 0: sum ← d, thr_hi/thr_lo captured, err/sat cleared.
  - Later chunks: sum ← sum + d.
- Final beat is when the chunk counter equals N_CHUNKS−1, or in_last is 1.
  - On the final beat: go to HOLD, counter → 0, and register the result.
  - out_err = 1 if in_last ≠ (counter == N_CHUNKS−1): early last, or missing last on the Nth chunk.
  - The early-last case still finalises on that beat.
- Activation, computed on the final sum:
  - +1 if sum > thr_hi_s.
  - Else −1 if sum < thr_lo_s.
  - Else 0.
  - Signed compares. If thr_lo_s > thr_hi_s, the +1 test has priority.
- Latency: final beat accepted at cycle t → out_valid = 1 at t+1.
- HOLD: out_act/out_sum/out_err/out_sat stay stable until out_valid & out_ready, then return to ACC.
  - in_ready is 0 throughout HOLD, including the handshake cycle.
  - Throughput is at best one neuron per N_CHUNKS+1 cycles.
- in_valid while in_ready = 0 is ignored; the producer must hold the beat.
- Overflow without the feature: two's-complement wrap modulo 2^ACC_W; out_sat = 0.
- N_CHUNKS = 1: every accepted beat is final; out_err = ~in_last.

Optional Feature:
- Macro: TNEURON_SAT_EN.
- Defined:
  - Each accumulate clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Any clamp sets the sticky sat flag, reported on out_sat.
  - The chunk-0 load cannot clamp, since ACC_W ≥ 6.
- Undefined:
  - Accumulation wraps.
  - out_sat is tied to 0.
  - No clamp logic is synthesised.

Test Plan:
- Reset: hold rst for 3 cycles during chunk 2, then release.
  - Next cycle: in_ready = 1, out_valid = 0.
  - Following evaluation: chunk-0 (pos 3, neg 0) loads sum = 3; no stale sum is carried over.
- Nominal, defaults, thr_hi = 5, thr_lo = −5: beats (pos, neg) = (10,2), (7,7), (3,9), (20,18), last on beat 4.
  - Sum = 4, out_act = 2'b00, out_err = 0.
  - out_valid at the cycle after beat 4.
- Positive and negative activation: same thresholds.
  - All beats (12,0): sum = 48, act = 01.
  - All beats (0,12): sum = −48, act = 11.
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1.
  - in_ready = 0 throughout; outputs stable.
  - After the out_ready pulse, the next beat is accepted one cycle later.
- Framing errors:
  - in_last on beat 2 → result after beat 2, out_err = 1.
  - No in_last on beat 4 → result after beat 4, out_err = 1.
- Overflow, ACC_W = 6, N_CHUNKS = 2: two beats of (31,0).
  - Without TNEURON_SAT_EN: out_sum = −2, out_sat = 0.
  - With TNEURON_SAT_EN: out_sum = 31, out_sat = 1.

Source files
------------

// File: rtl/ternary_neuron_accum.sv
// Ternary neuron accumulator: sums signed popcount differences over N_CHUNKS beats,
// thresholds the total and holds a 2-bit activation. Optional clamping via TNEURON_SAT_EN.
module ternary_neuron_accum #(
   parameter int N_CHUNKS = 4,
   parameter int ACC_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       pos_cnt,
   input  logic [4:0]       neg_cnt,
   input  logic             in_last,
   input  logic [ACC_W-1:0] thr_hi,
   input  logic [ACC_W-1:0] thr_lo,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_act,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_err,
   output logic             out_sat
);

   localparam int CNT_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CHUNKS - 1);

   typedef enum logic {ACC, HOLD} state_t;

   state_t                  state_reg, state_next;
   logic signed [ACC_W-1:0] sum_reg, sum_next, add_res;
   logic signed [ACC_W-1:0] thr_hi_reg, thr_lo_reg, thr_hi_eff, thr_lo_eff;
   logic [CNT_W-1:0]        cnt_reg;
   logic                    sat_reg, sat_next, clamp;
   logic signed [5:0]       diff;
   logic signed [ACC_W-1:0] diff_ext;
   logic                    accept, first, last_cnt, final_beat;
   logic [1:0]              act_next;
   logic [1:0]              act_reg;
   logic [ACC_W-1:0]        out_sum_reg;
   logic                    err_reg, out_sat_reg;

`ifdef TNEURON_SAT_EN
   localparam logic signed [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   logic signed [ACC_W:0] wide_sum;
`endif

   always_comb begin
      accept     = in_valid && in_ready;
      first      = (cnt_reg == '0);
      last_cnt   = (cnt_reg == LAST_CNT);
      final_beat = last_cnt || in_last;
      // Popcounts may reach 31, so the difference needs the full 6-bit signed range.
      diff       = $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});
      diff_ext   = ACC_W'(diff);
   end

`ifdef TNEURON_SAT_EN
   always_comb begin
      wide_sum = {sum_reg[ACC_W-1], sum_reg} + {diff_ext[ACC_W-1], diff_ext};
      clamp    = (wide_sum[ACC_W] != wide_sum[ACC_W-1]);
      if (clamp)
         add_res = wide_sum[ACC_W] ? SUM_MIN : SUM_MAX;
      else
         add_res = wide_sum[ACC_W-1:0];
   end
`else
   always_comb begin
      add_res = sum_reg + diff_ext;
      clamp   = 1'b0;
   end
`endif

   always_comb begin
      sum_next   = first ? diff_ext : add_res;
      sat_next   = first ? 1'b0 : (sat_reg || clamp);
      // Thresholds arriving with chunk 0 must apply even when that beat is also final.
      thr_hi_eff = first ? $signed(thr_hi) : thr_hi_reg;
      thr_lo_eff = first ? $signed(thr_lo) : thr_lo_reg;
      if (sum_next > thr_hi_eff)
         act_next = 2'b01;
      else if (sum_next < thr_lo_eff)
         act_next = 2'b11;
      else
         act_next = 2'b00;
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         ACC: begin
            in_ready = 1'b1;
            if (accept && final_beat)
               state_next = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready)
               state_next = ACC;
         end
         default: state_next = ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ACC;
         sum_reg     <= '0;
         cnt_reg     <= '0;
         thr_hi_reg  <= '0;
         thr_lo_reg  <= '0;
         sat_reg     <= 1'b0;
         act_reg     <= 2'b00;
         out_sum_reg <= '0;
         err_reg     <= 1'b0;
         out_sat_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            sum_reg <= sum_next;
            sat_reg <= sat_next;
            cnt_reg <= final_beat ? '0 : cnt_reg + CNT_W'(1);
            if (first) begin
               thr_hi_reg <= $signed(thr_hi);
               thr_lo_reg <= $signed(thr_lo);
            end
            if (final_beat) begin
               act_reg     <= act_next;
               out_sum_reg <= sum_next;
               err_reg     <= in_last ^ last_cnt;
               out_sat_reg <= sat_next;
            end
         end
      end
   end

   assign out_act = act_reg;
   assign out_sum = out_sum_reg;
   assign out_err = err_reg;
   assign out_sat = out_sat_reg;

endmodule

// File: tb/tb_ternary_neuron_accum.sv
// Directed bench for ternary_neuron_accum: default instance (N_CHUNKS=4, ACC_W=8)
// plus a narrow instance (N_CHUNKS=2, ACC_W=6) for overflow behaviour.
module tb_ternary_neuron_accum;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         checks = 0;
   int         errors = 0;

   logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [4:0] pos_cnt = '0, neg_cnt = '0;
   logic [7:0] thr_hi = '0, thr_lo = '0;
   logic       in_ready, out_valid, out_err, out_sat;
   logic [1:0] out_act;
   logic [7:0] out_sum;

   logic       b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b0;
   logic [4:0] b_pos_cnt = '0, b_neg_cnt = '0;
   logic [5:0] b_thr_hi = '0, b_thr_lo = '0;
   logic       b_in_ready, b_out_valid, b_out_err, b_out_sat;
   logic [1:0] b_out_act;
   logic [5:0] b_out_sum;

   always #5 clk = ~clk;

   ternary_neuron_accum #(.N_CHUNKS(4), .ACC_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .pos_cnt(pos_cnt), .neg_cnt(neg_cnt), .in_last(in_last),
      .thr_hi(thr_hi), .thr_lo(thr_lo), .out_valid(out_valid), .out_ready(out_ready),
      .out_act(out_act), .out_sum(out_sum), .out_err(out_err), .out_sat(out_sat)
   );

   ternary_neuron_accum #(.N_CHUNKS(2), .ACC_W(6)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .pos_cnt(b_pos_cnt), .neg_cnt(b_neg_cnt), .in_last(b_in_last),
      .thr_hi(b_thr_hi), .thr_lo(b_thr_lo), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_act(b_out_act), .out_sum(b_out_sum), .out_err(b_out_err), .out_sat(b_out_sat)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [4:0] p, input logic [4:0] n, input logic l);
      in_valid = 1'b1;
      pos_cnt  = p;
      neg_cnt  = n;
      in_last  = l;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [7:0] sum, input logic [1:0] act,
                               input logic err);
      $display("result %s: valid=%0b sum=%0d act=%b err=%0b sat=%0b",
               tag, out_valid, $signed(out_sum), out_act, out_err, out_sat);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_sum"},   32'(out_sum),   32'(sum));
      chk({tag, "_act"},   32'(out_act),   32'(act));
      chk({tag, "_err"},   32'(out_err),   32'(err));
      chk({tag, "_sat"},   32'(out_sat),   32'd0);
   endtask

   task automatic pop();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      rst    = 1'b0;
      thr_hi = 8'd5;
      thr_lo = 8'hFB;  // -5
      tick();
      chk("reset_in_ready",  32'(in_ready),  32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_sum",   32'(out_sum),   32'd0);
      chk("reset_out_act",   32'(out_act),   32'd0);

      // Partial evaluation interrupted by a 3-cycle reset during chunk 2.
      beat(5'd9, 5'd0, 1'b0);
      beat(5'd9, 5'd0, 1'b0);
      in_valid = 1'b1;
      pos_cnt  = 5'd9;
      rst      = 1'b1;
      tick(); tick(); tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("post_rst_in_ready",  32'(in_ready),  32'd1);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      beat(5'd3, 5'd0, 1'b0);
      beat(5'd0, 5'd0, 1'b0);
      beat(5'd0, 5'd0, 1'b0);
      beat(5'd0, 5'd0, 1'b1);
      check_result("after_reset", 8'd3, 2'b00, 1'b0);
      pop();

      // Nominal: 8 + 0 - 6 + 2 = 4.
      beat(5'd10, 5'd2, 1'b0);
      beat(5'd7,  5'd7, 1'b0);
      beat(5'd3,  5'd9, 1'b0);
      chk("nominal_not_yet_valid", 32'(out_valid), 32'd0);
      beat(5'd20, 5'd18, 1'b1);
      check_result("nominal", 8'd4, 2'b00, 1'b0);
      pop();

      for (int i = 0; i < 4; i++) beat(5'd12, 5'd0, (i == 3));
      check_result("positive", 8'd48, 2'b01, 1'b0);
      pop();

      for (int i = 0; i < 4; i++) beat(5'd0, 5'd12, (i == 3));
      check_result("negative", 8'hD0, 2'b11, 1'b0);

      // Backpressure with a beat held on the input.
      in_valid = 1'b1;
      pos_cnt  = 5'd2;
      neg_cnt  = 5'd0;
      in_last  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_in_ready",  32'(in_ready),  32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_sum",   32'(out_sum),   32'hD0);
         chk("bp_out_act",   32'(out_act),   32'b11);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_release_in_ready",  32'(in_ready),  32'd1);
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);
      tick();  // held beat (2,0) accepted as chunk 0
      beat(5'd1, 5'd0, 1'b1);  // early last on beat 2
      check_result("early_last", 8'd3, 2'b00, 1'b1);
      pop();

      for (int i = 0; i < 4; i++) beat(5'd1, 5'd0, 1'b0);
      check_result("missing_last", 8'd4, 2'b00, 1'b1);
      pop();

      // Thresholds must be taken from chunk 0 only: 31 + 31 - 31 + 0 = 31.
      beat(5'd31, 5'd0, 1'b0);
      thr_hi = 8'd100;
      beat(5'd31, 5'd0, 1'b0);
      beat(5'd0, 5'd31, 1'b0);
      beat(5'd31, 5'd31, 1'b1);
      check_result("thr_sampled", 8'd31, 2'b01, 1'b0);
      pop();

      // Inverted thresholds: +1 test wins.
      thr_hi = 8'hF6;  // -10
      thr_lo = 8'd10;
      for (int i = 0; i < 4; i++) beat(5'd0, 5'd0, (i == 3));
      check_result("thr_priority", 8'd0, 2'b01, 1'b0);
      pop();

      // Narrow instance overflow: 31 + 31 in 6 bits.
      b_in_valid = 1'b1;
      b_pos_cnt  = 5'd31;
      b_neg_cnt  = 5'd0;
      b_in_last  = 1'b0;
      tick();
      b_in_last  = 1'b1;
      tick();
      b_in_valid = 1'b0;
      b_in_last  = 1'b0;
      $display("result overflow: valid=%0b sum=%0d act=%b err=%0b sat=%0b",
               b_out_valid, $signed(b_out_sum), b_out_act, b_out_err, b_out_sat);
      chk("ovf_valid", 32'(b_out_valid), 32'd1);
      chk("ovf_err",   32'(b_out_err),   32'd0);
`ifdef TNEURON_SAT_EN
      chk("ovf_sum", 32'(b_out_sum), 32'h1F);
      chk("ovf_sat", 32'(b_out_sat), 32'd1);
      chk("ovf_act", 32'(b_out_act), 32'b01);
`else
      chk("ovf_sum", 32'(b_out_sum), 32'h3E);
      chk("ovf_sat", 32'(b_out_sat), 32'd0);
      chk("ovf_act", 32'(b_out_act), 32'b11);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
